// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment pattern table and anode classification helpers
package seg7_pkg;

   // Active-low segment patterns {dp,g,f,e,d,c,b,a}, dp held off (1).
   // The display encoder and this decoder both use this single table.
   localparam logic [7:0] SEG_0 = 8'hC0;
   localparam logic [7:0] SEG_1 = 8'hF9;
   localparam logic [7:0] SEG_2 = 8'hA4;
   localparam logic [7:0] SEG_3 = 8'hB0;
   localparam logic [7:0] SEG_4 = 8'h99;
   localparam logic [7:0] SEG_5 = 8'h92;
   localparam logic [7:0] SEG_6 = 8'h82;
   localparam logic [7:0] SEG_7 = 8'hF8;
   localparam logic [7:0] SEG_8 = 8'h80;
   localparam logic [7:0] SEG_9 = 8'h90;

   localparam logic [7:0] SEG_BLANK     = 8'hFF;
   localparam logic [3:0] DIGIT_INVALID = 4'hF;

   // All anodes released: the idle value of the active-low anode bus.
   localparam logic [7:0] ANODE_NONE = 8'hFF;

   typedef enum logic [1:0] {
      ANODE_BLANK = 2'd0,
      ANODE_SLOT  = 2'd1,
      ANODE_MULTI = 2'd2
   } anode_class_e;

   typedef struct packed {
      anode_class_e cls;
      logic [2:0]   slot;
   } anode_info_t;

   // Encoder-side helper: BCD digit to active-low pattern, blank for non-BCD.
   function automatic logic [7:0] seg7_encode(input logic [3:0] digit);
      logic [7:0] pat;
      case (digit)
         4'd0:    pat = SEG_0;
         4'd1:    pat = SEG_1;
         4'd2:    pat = SEG_2;
         4'd3:    pat = SEG_3;
         4'd4:    pat = SEG_4;
         4'd5:    pat = SEG_5;
         4'd6:    pat = SEG_6;
         4'd7:    pat = SEG_7;
         4'd8:    pat = SEG_8;
         4'd9:    pat = SEG_9;
         default: pat = SEG_BLANK;
      endcase
      return pat;
   endfunction

   // Classify an active-low anode word: one low bit inside the decoded range is
   // a slot, no low bit (or one outside the range) is blank, two or more is a fault.
   function automatic anode_info_t classify_anode(input logic [7:0] anode,
                                                  input int         num_digits);
      anode_info_t info;
      int          lows;
      info.cls  = ANODE_BLANK;
      info.slot = 3'd0;
      lows      = 0;
      for (int i = 0; i < 8; i++) begin
         if (!anode[i]) begin
            lows++;
            info.slot = 3'(i);
         end
      end
      if (lows >= 2) begin
         info.cls = ANODE_MULTI;
      end else if (lows == 1 && int'(info.slot) < num_digits) begin
         info.cls = ANODE_SLOT;
      end
      return info;
   endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - active-low 7-segment pattern to BCD digit decoder
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [7:0] pattern,
   output logic [3:0] digit,
   output logic       valid
);

   logic [7:0] pat_nodp;

   // Force the decimal point off so it never affects the match, then look up the table.
   always_comb begin
      pat_nodp = pattern | 8'h80;
      digit    = DIGIT_INVALID;
      valid    = 1'b1;
      case (pat_nodp)
         SEG_0:   digit = 4'd0;
         SEG_1:   digit = 4'd1;
         SEG_2:   digit = 4'd2;
         SEG_3:   digit = 4'd3;
         SEG_4:   digit = 4'd4;
         SEG_5:   digit = 4'd5;
         SEG_6:   digit = 4'd6;
         SEG_7:   digit = 4'd7;
         SEG_8:   digit = 4'd8;
         SEG_9:   digit = 4'd9;
         default: valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - multiplexed 7-segment bus monitor: scan tracking and frame assembly
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 2,
   parameter int SETTLE     = 4,
   parameter int TIMEOUT    = 400_000
)(
   input  logic                    clk,
   input  logic                    clr,
   input  logic [7:0]              seg_7_display,
   input  logic [7:0]              active_low_anode,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic                    number_valid,
   output logic                    frame_changed,
   output logic                    pattern_error,
   output logic                    anode_error,
   output logic                    display_stalled
);

   localparam int DW = 4 * NUM_DIGITS;
   localparam int SW = $clog2(SETTLE + 1);
   localparam int IW = $clog2(TIMEOUT + 1);

   localparam logic [SW-1:0] SETTLE_MAX    = SW'(SETTLE);
   localparam logic [SW-1:0] SETTLE_SAMPLE = SW'(SETTLE - 1);
   localparam logic [IW-1:0] IDLE_MAX      = IW'(TIMEOUT);

   // Registered state
   logic [7:0]            anode_prev_q, anode_prev_d;
   logic [SW-1:0]         settle_q, settle_d;
   logic [NUM_DIGITS-1:0] mask_q, mask_d;
   logic [DW-1:0]         shadow_q, shadow_d;
   logic [IW-1:0]         idle_q, idle_d;
   logic [DW-1:0]         digits_q, digits_d;
   logic                  number_valid_q, number_valid_d;
   logic                  frame_changed_q, frame_changed_d;
   logic                  pattern_error_q, pattern_error_d;
   logic                  anode_error_q, anode_error_d;

   // Combinational helpers
   anode_info_t           anode_info;
   logic                  sample;
   logic [NUM_DIGITS-1:0] slot_bit;
   logic [NUM_DIGITS-1:0] mask_merged;
   logic [DW-1:0]         shadow_merged;
   logic                  frame_done;
   logic [3:0]            dec_digit;
   logic                  dec_valid;

   seg7_pattern_decode u_decode (
      .pattern (seg_7_display),
      .digit   (dec_digit),
      .valid   (dec_valid)
   );

   // Classify the current anode word into slot / blank / multi-driven.
   always_comb begin
      anode_info = classify_anode(active_low_anode, NUM_DIGITS);
   end

   // Settle tracking: restart on any anode change, saturate once settled; sample exactly once
   // per stable period, on the clock where the running count reaches SETTLE-1.
   always_comb begin
      anode_prev_d = active_low_anode;
      if (active_low_anode != anode_prev_q) begin
         settle_d = '0;
      end else if (settle_q == SETTLE_MAX) begin
         settle_d = settle_q;
      end else begin
         settle_d = settle_q + 1'b1;
      end
      sample = (settle_d == SETTLE_SAMPLE) && (anode_info.cls == ANODE_SLOT);
   end

   // Frame assembly: merge this cycle's sample into the shadow/mask, publish on a full mask.
   always_comb begin
      slot_bit      = '0;
      shadow_merged = shadow_q;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (sample && anode_info.slot == 3'(k)) begin
            slot_bit[k]           = 1'b1;
            shadow_merged[4*k +: 4] = dec_digit;
         end
      end
      mask_merged     = mask_q | slot_bit;
      frame_done      = sample && (&mask_merged);

      shadow_d        = shadow_merged;
      mask_d          = frame_done ? '0 : mask_merged;
      digits_d        = frame_done ? shadow_merged : digits_q;
      number_valid_d  = frame_done;
      frame_changed_d = frame_done && (shadow_merged != digits_q);
   end

   // Sticky error flags and the idle (no-capture) counter.
   always_comb begin
      pattern_error_d = pattern_error_q | (sample & ~dec_valid);
      anode_error_d   = anode_error_q | (anode_info.cls == ANODE_MULTI);
      if (sample) begin
         idle_d = '0;
      end else if (idle_q == IDLE_MAX) begin
         idle_d = idle_q;
      end else begin
         idle_d = idle_q + 1'b1;
      end
   end

   // State registers; clr discards any partial frame immediately.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         anode_prev_q    <= ANODE_NONE;
         settle_q        <= '0;
         mask_q          <= '0;
         shadow_q        <= '0;
         idle_q          <= '0;
         digits_q        <= '0;
         number_valid_q  <= 1'b0;
         frame_changed_q <= 1'b0;
         pattern_error_q <= 1'b0;
         anode_error_q   <= 1'b0;
      end else begin
         anode_prev_q    <= anode_prev_d;
         settle_q        <= settle_d;
         mask_q          <= mask_d;
         shadow_q        <= shadow_d;
         idle_q          <= idle_d;
         digits_q        <= digits_d;
         number_valid_q  <= number_valid_d;
         frame_changed_q <= frame_changed_d;
         pattern_error_q <= pattern_error_d;
         anode_error_q   <= anode_error_d;
      end
   end

   assign digits          = digits_q;
   assign number_valid    = number_valid_q;
   assign frame_changed   = frame_changed_q;
   assign pattern_error   = pattern_error_q;
   assign anode_error     = anode_error_q;
   assign display_stalled = (idle_q == IDLE_MAX);

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - self-checking bench for seg7_scan_decoder
module tb_seg7_scan_decoder;

   localparam int N  = 2;
   localparam int ST = 4;
   localparam int TO = 200;

   localparam logic [7:0] TBL [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                       8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   logic           clk = 1'b0;
   logic           clr = 1'b1;
   logic [7:0]     seg_7_display = 8'hFF;
   logic [7:0]     active_low_anode = 8'hFF;
   logic [4*N-1:0] digits;
   logic           number_valid;
   logic           frame_changed;
   logic           pattern_error;
   logic           anode_error;
   logic           display_stalled;

   int n_tests = 0;
   int n_fail  = 0;

   seg7_scan_decoder #(.NUM_DIGITS(N), .SETTLE(ST), .TIMEOUT(TO)) dut (
      .clk              (clk),
      .clr              (clr),
      .seg_7_display    (seg_7_display),
      .active_low_anode (active_low_anode),
      .digits           (digits),
      .number_valid     (number_valid),
      .frame_changed    (frame_changed),
      .pattern_error    (pattern_error),
      .anode_error      (anode_error),
      .display_stalled  (display_stalled)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- behavioural model ----------------
   logic [7:0]     m_last;
   int             m_run;
   logic [3:0]     m_shadow [N];
   bit             m_have [N];
   int             m_idle;
   logic [4*N-1:0] exp_digits;
   bit             exp_valid, exp_changed, exp_perr, exp_aerr, exp_stall;

   int             valid_count = 0;
   logic [4*N-1:0] last_digits = '0;
   logic           last_changed = 1'b0;

   function automatic logic [3:0] model_decode(input logic [7:0] s);
      logic [7:0] p;
      p = s | 8'h80;
      for (int i = 0; i < 10; i++) if (p == TBL[i]) return 4'(i);
      return 4'hF;
   endfunction

   task automatic model_reset();
      m_last = 8'hFF;
      m_run  = 1;
      m_idle = 0;
      for (int k = 0; k < N; k++) begin
         m_shadow[k] = 4'h0;
         m_have[k]   = 1'b0;
      end
      exp_digits = '0;
      exp_valid = 0; exp_changed = 0; exp_perr = 0; exp_aerr = 0; exp_stall = 0;
   endtask

   // Run-length view of the scan: a slot is read when its anode has been steady for ST clocks.
   task automatic model_step(input logic [7:0] a, input logic [7:0] s);
      int zeros, idx;
      bit all;
      logic [4*N-1:0] nd;
      logic [3:0] d;
      exp_valid = 0;
      exp_changed = 0;
      if (a != m_last) m_run = 1;
      else if (m_run < 1000000) m_run++;
      m_last = a;
      zeros = 0; idx = 0;
      for (int i = 0; i < 8; i++) if (!a[i]) begin zeros++; idx = i; end
      if (zeros >= 2) exp_aerr = 1;
      if (zeros == 1 && idx < N && m_run == ST) begin
         d = model_decode(s);
         if (d == 4'hF) exp_perr = 1;
         m_shadow[idx] = d;
         m_have[idx]   = 1'b1;
         m_idle = 0;
         all = 1;
         for (int k = 0; k < N; k++) if (!m_have[k]) all = 0;
         if (all) begin
            for (int k = 0; k < N; k++) begin
               nd[4*k +: 4] = m_shadow[k];
               m_have[k] = 1'b0;
            end
            exp_changed = (nd != exp_digits);
            exp_digits  = nd;
            exp_valid   = 1;
         end
      end else if (m_idle < TO) begin
         m_idle++;
      end
      exp_stall = (m_idle == TO);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
      end
   endtask

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      if (clr) model_reset();
      chk("digits", 32'(digits), 32'(exp_digits));
      chk("number_valid", 32'(number_valid), 32'(exp_valid));
      chk("frame_changed", 32'(frame_changed), 32'(exp_changed));
      chk("pattern_error", 32'(pattern_error), 32'(exp_perr));
      chk("anode_error", 32'(anode_error), 32'(exp_aerr));
      chk("display_stalled", 32'(display_stalled), 32'(exp_stall));
      if (number_valid === 1'b1) begin
         valid_count++;
         last_digits  = digits;
         last_changed = frame_changed;
      end
      if (!clr) model_step(active_low_anode, seg_7_display);
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic hold(input logic [7:0] a, input logic [7:0] s, input int n);
      active_low_anode = a;
      seg_7_display    = s;
      repeat (n) tick();
   endtask

   // Encoder-style scan, 8 clocks per slot, segments lagging the anode by one clock.
   task automatic scan_frame(input logic [3:0] d0, input logic [3:0] d1);
      logic [3:0] d;
      for (int k = 0; k < 2; k++) begin
         d = (k == 0) ? d0 : d1;
         active_low_anode = 8'(~(8'h01 << k));
         tick();
         seg_7_display = TBL[d];
         repeat (7) tick();
      end
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_digits"}, 32'(digits), 32'h0);
      chk({tag, "_valid"}, 32'(number_valid), 32'h0);
      chk({tag, "_changed"}, 32'(frame_changed), 32'h0);
      chk({tag, "_perr"}, 32'(pattern_error), 32'h0);
      chk({tag, "_aerr"}, 32'(anode_error), 32'h0);
      chk({tag, "_stall"}, 32'(display_stalled), 32'h0);
   endtask

   initial begin
      int vc0;
      int r;
      logic [7:0] a, s;

      repeat (3) tick();
      reset_checks("reset");
      clr = 1'b0;
      tick();

      // Encoder-driven frames 42 then 42 again
      scan_frame(4'd2, 4'd4);
      chk("enc1_digits", 32'(last_digits), 32'h42);
      chk("enc1_changed", 32'(last_changed), 32'h1);
      chk("enc1_count", 32'(valid_count), 32'd1);
      scan_frame(4'd2, 4'd4);
      chk("enc2_changed", 32'(last_changed), 32'h0);
      chk("enc2_count", 32'(valid_count), 32'd2);
      chk("enc_perr", 32'(pattern_error), 32'h0);
      chk("enc_aerr", 32'(anode_error), 32'h0);

      // Two slots -> 75, valid one clock after the second sample point
      hold(8'hFF, 8'hFF, 2);
      hold(8'hFE, 8'h92, ST);
      hold(8'hFD, 8'hF8, ST);
      chk("d75_digits", 32'(digits), 32'h75);
      chk("d75_valid", 32'(number_valid), 32'h1);
      tick();
      chk("d75_pulse_len", 32'(number_valid), 32'h0);

      // Short slot-0 pulse is rejected
      hold(8'hFF, 8'hFF, 2);
      vc0 = valid_count;
      hold(8'hFE, 8'hC0, ST - 1);
      hold(8'hFD, 8'h99, ST);
      tick();
      chk("glitch_noframe", 32'(valid_count), 32'(vc0));
      hold(8'hFE, 8'hA4, ST);
      chk("glitch_digits", 32'(digits), 32'h42);
      chk("glitch_valid", 32'(number_valid), 32'h1);

      // Unrecognised pattern in slot 0
      hold(8'hFF, 8'hFF, 2);
      hold(8'hFE, 8'hFF, ST);
      hold(8'hFD, 8'hC0, ST);
      chk("perr_digits", 32'(digits), 32'h0F);
      chk("perr_flag", 32'(pattern_error), 32'h1);
      hold(8'hFF, 8'hFF, 2);
      scan_frame(4'd3, 4'd1);
      chk("perr_clean_digits", 32'(last_digits), 32'h13);
      chk("perr_sticky", 32'(pattern_error), 32'h1);

      // Multi-driven anodes keep the mask
      hold(8'hFF, 8'hFF, 2);
      vc0 = valid_count;
      hold(8'hFE, 8'h90, ST);
      hold(8'hFC, 8'hC0, 10);
      chk("multi_aerr", 32'(anode_error), 32'h1);
      chk("multi_noframe", 32'(valid_count), 32'(vc0));
      hold(8'hFD, 8'hF9, ST);
      chk("multi_digits", 32'(digits), 32'h19);
      chk("multi_valid", 32'(number_valid), 32'h1);

      // Stall detection and release
      hold(8'hFF, 8'hFF, TO + 5);
      chk("stall_set", 32'(display_stalled), 32'h1);
      hold(8'hFE, 8'h82, ST - 1);
      chk("stall_before_sample", 32'(display_stalled), 32'h1);
      hold(8'hFE, 8'h82, 1);
      chk("stall_drop", 32'(display_stalled), 32'h0);

      // Reset mid-frame discards the captured slot 0
      clr = 1'b1;
      tick();
      tick();
      reset_checks("midclr");
      clr = 1'b0;
      hold(8'hFF, 8'hFF, 2);
      vc0 = valid_count;
      hold(8'hFD, 8'hB0, ST);
      tick();
      chk("midclr_noframe", 32'(valid_count), 32'(vc0));
      hold(8'hFE, 8'h99, ST);
      chk("midclr_digits", 32'(digits), 32'h34);
      chk("midclr_valid", 32'(number_valid), 32'h1);

      // Randomised scan traffic checked by the model every cycle
      for (int it = 0; it < 300; it++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2: a = 8'hFE;
            3, 4, 5: a = 8'hFD;
            6:       a = 8'hFF;
            7:       a = 8'hFB;
            8:       a = 8'hFC;
            default: a = 8'($urandom);
         endcase
         if ($urandom_range(0, 4) != 0)
            s = TBL[$urandom_range(0, 9)] & {1'($urandom), 7'h7F};
         else
            s = 8'($urandom);
         hold(a, s, $urandom_range(1, 7));
      end
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
